// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, FSM encoding,
// and the table of which source fields each opcode reads.
package hazard_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  localparam logic [4:0] OP_HALT = 5'd0;
  localparam logic [4:0] OP_NOP  = NOP_INSTR[15:11];
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_ADDI = 5'd6;
  localparam logic [4:0] OP_LD   = 5'd7;
  localparam logic [4:0] OP_ST   = 5'd8;
  localparam logic [4:0] OP_BEQ  = 5'd9;
  localparam logic [4:0] OP_JR   = 5'd10;
  localparam logic [4:0] OP_J    = 5'd11;
  localparam logic [4:0] OP_LUI  = 5'd12;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic rs;
    logic rt;
  } src_use_t;

  // Which of rs ([10:8]) / rt ([7:5]) an opcode actually reads.
  function automatic src_use_t src_use(input logic [4:0] opcode);
    src_use_t u;
    u = '{rs: 1'b0, rt: 1'b0};
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST, OP_BEQ: u = '{rs: 1'b1, rt: 1'b1};
      OP_ADDI, OP_LD, OP_JR:                        u.rs = 1'b1;
      OP_HALT, OP_NOP, OP_J, OP_LUI:                u = '{rs: 1'b0, rt: 1'b0};
      default:                                      u = '{rs: 1'b0, rt: 1'b0};
    endcase
    return u;
  endfunction

endpackage

// File: rtl/hazard_src_decode.sv
// Source-operand decode of the instruction held in IF/ID: register fields and
// whether each field is really read.
module hazard_src_decode
  import hazard_pkg::*;
(
  input  logic [15:0] instr,
  output logic [2:0]  rs,
  output logic [2:0]  rt,
  output logic        reads_rs,
  output logic        reads_rt
);

  src_use_t use_q;
  logic     unused_low_bits;

  assign use_q    = src_use(instr[15:11]);
  assign rs       = instr[10:8];
  assign rt       = instr[7:5];
  assign reads_rs = use_q.rs;
  assign reads_rt = use_q.rt;

  // Destination/function bits never take part in hazard detection.
  assign unused_low_bits = ^instr[4:0];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stall detection against in-flight writers
// (no forwarding) and wrong-path flush sequencing after a taken branch/jump.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter bit CHECK_MEMWB  = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      IFID_instr,
  input  logic             IDEX_wr_en,
  input  logic [2:0]       IDEX_wr_reg,
  input  logic             EXMEM_wr_en,
  input  logic [2:0]       EXMEM_wr_reg,
  input  logic             MEMWB_wr_en,
  input  logic [2:0]       MEMWB_wr_reg,
  input  logic             EX_br_taken,
  input  logic             mem_stall,
  output logic             NOP_mech,
  output logic             NOP_Branch,
  output logic             PC_we,
  output logic             IDEX_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0]       FLUSH_CTR_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

  logic [2:0] rs, rt;
  logic       reads_rs, reads_rt;
  logic       rs_hit, rt_hit, raw;

  hz_state_e  state;
  logic [1:0] flush_ctr;
  logic       in_flush;

  hazard_src_decode u_src_decode (
    .instr    (IFID_instr),
    .rs       (rs),
    .rt       (rt),
    .reads_rs (reads_rs),
    .reads_rt (reads_rt)
  );

  // Register 0 is an ordinary register here, so no zero-register exemption.
  assign rs_hit = (IDEX_wr_en && IDEX_wr_reg == rs) ||
                  (EXMEM_wr_en && EXMEM_wr_reg == rs) ||
                  (CHECK_MEMWB && MEMWB_wr_en && MEMWB_wr_reg == rs);
  assign rt_hit = (IDEX_wr_en && IDEX_wr_reg == rt) ||
                  (EXMEM_wr_en && EXMEM_wr_reg == rt) ||
                  (CHECK_MEMWB && MEMWB_wr_en && MEMWB_wr_reg == rt);
  assign raw      = (reads_rs && rs_hit) || (reads_rt && rt_hit);
  assign in_flush = (state == FLUSH);

  // Outputs follow the current cycle's inputs so a stall releases the same
  // cycle the hazard clears.
  always_comb begin
    // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned and no latch is inferred.
    NOP_mech    = 1'b0;
    NOP_Branch  = 1'b0;
    PC_we       = 1'b1;
    IDEX_bubble = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        NOP_mech = 1'b1;
        PC_we    = 1'b0;
      end else if (EX_br_taken) begin
        NOP_Branch  = 1'b1;
        IDEX_bubble = 1'b1;
      end else if (in_flush) begin
        NOP_Branch = 1'b1;
      end else if (raw) begin
        NOP_mech    = 1'b1;
        PC_we       = 1'b0;
        IDEX_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every branch reads pre-edge values regardless of statement order.
    if (rst) begin
      state       <= RUN;
      flush_ctr   <= 2'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (!mem_stall) begin
      if (EX_br_taken) begin
        flush_ctr   <= FLUSH_CTR_INIT;
        state       <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        flush_count <= (&flush_count) ? flush_count : flush_count + CNT_ONE;
      end else if (in_flush) begin
        flush_ctr <= flush_ctr - 2'd1;
        if (flush_ctr == 2'd1) state <= RUN;
      end else if (raw) begin
        state       <= STALL;
        stall_count <= (&stall_count) ? stall_count : stall_count + CNT_ONE;
      end else begin
        state <= RUN;
      end
    end
  end

endmodule
